// File: rtl/hbm_fc_pkg.sv
// Shared constants, derived widths and FSM state type for the HBM FC weight/scale unpacker.
// The stream geometry is fixed here. WT_CH_TGROUP must equal T_QUANT_BLOCK*HBM_DW/SCALE_DW,
// so that one scale beat carries exactly one group's block scales.
package hbm_fc_pkg;

  localparam int unsigned HBM_DW        = 256;
  localparam int unsigned WT_DW         = 4;
  localparam int unsigned SCALE_DW      = 16;
  localparam int unsigned T_QUANT_BLOCK = 128;
  localparam int unsigned WT_CH_TGROUP  = 2048;
  localparam int unsigned CHIN_W        = 16;
  localparam int unsigned ROWS_W        = 16;

  // Beats per full group and beats per quant block.
  localparam int unsigned GB      = WT_CH_TGROUP * WT_DW / HBM_DW;
  localparam int unsigned BB      = T_QUANT_BLOCK * WT_DW / HBM_DW;
  localparam int unsigned CNT_W   = $clog2(GB + 1);
  // Full groups plus one trailing partial group.
  localparam int unsigned GRP_W   = CHIN_W - $clog2(WT_CH_TGROUP) + 1;
  localparam int unsigned SCALE_N = HBM_DW / SCALE_DW;
  localparam int unsigned SIDX_W  = $clog2(SCALE_N);

  typedef enum logic [1:0] {StIdle, StFill, StScale, StDrain} state_e;

  // Number of HBM beats that carry n weight elements.
  function automatic int unsigned wt_beats(input int unsigned n);
    return n * WT_DW / HBM_DW;
  endfunction

endpackage

// File: rtl/hbm_fc_wt_scale_unpacker_if.sv
// Stream bundle of the unpacker: the raw HBM read stream in, and the scale-tagged weight
// stream out.
//   master: the unpacker side (consumes hbm_*, produces wt_*)
//   slave : the environment side (produces hbm_*, consumes wt_*)
interface hbm_fc_wt_scale_unpacker_if;
  import hbm_fc_pkg::*;

  logic [HBM_DW-1:0]   hbm_data;
  logic                hbm_valid;
  logic                hbm_ready;
  logic [HBM_DW-1:0]   wt_data;
  logic [SCALE_DW-1:0] wt_scale;
  logic                wt_valid;
  logic                wt_ready;
  logic                wt_last;
  logic                wt_last_row;

  modport master (
    input  hbm_data, hbm_valid, wt_ready,
    output hbm_ready, wt_data, wt_scale, wt_valid, wt_last, wt_last_row
  );

  modport slave (
    output hbm_data, hbm_valid, wt_ready,
    input  hbm_ready, wt_data, wt_scale, wt_valid, wt_last, wt_last_row
  );

endinterface

// File: rtl/hbm_fc_wt_fifo.sv
// Synchronous first-word-fall-through FIFO holding one group of weight beats.
//   push/push_data : write, ignored when full
//   pop            : drop head, ignored when empty
//   head           : current oldest entry (valid when !empty)
//   full/empty     : occupancy flags
//   clear          : synchronous flush of pointers and count
module hbm_fc_wt_fifo #(
  parameter int unsigned Width = 256,
  parameter int unsigned Depth = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (cnt_q == CntW'(Depth));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Storage needs no reset: reads are only meaningful while !empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/hbm_fc_wt_scale_unpacker.sv
// Buffers each group of HBM weight beats until the group's trailing scale beat arrives, then
// re-emits the weights tagged with the scale of their quant block.
//   clk, rst_n        : clock, async active-low reset
//   start             : one-cycle pulse, cfg_* sampled when idle
//   cfg_chin/cfg_rows : padded CHin per row, number of output-channel rows
//   busy/done         : busy from accepted start; done pulses after the final output beat
//   bus (master)      : hbm_* input stream, wt_* scale-tagged output stream
module hbm_fc_wt_scale_unpacker
  import hbm_fc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CHIN_W-1:0] cfg_chin,
  input  logic [ROWS_W-1:0] cfg_rows,
  output logic              busy,
  output logic              done,
  hbm_fc_wt_scale_unpacker_if.master bus
);

  state_e                             state_q, state_d;
  logic [CNT_W-1:0]                   beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]                   k_q, k_d;
  logic [CNT_W-1:0]                   last_beats_q, last_beats_d;
  logic [GRP_W-1:0]                   groups_q, groups_d;
  logic [GRP_W-1:0]                   grp_q, grp_d;
  logic [ROWS_W-1:0]                  rows_left_q, rows_left_d;
  logic [SCALE_N-1:0][SCALE_DW-1:0]   scale_q, scale_d;
  logic                               done_q, done_d;

  logic [CNT_W-1:0]  cfg_last_beats, gbeats;
  logic [SIDX_W-1:0] scale_idx;
  logic [HBM_DW-1:0] fifo_head;
  logic              last_group, last_row, grp_end, row_end, out_valid;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign cfg_last_beats = CNT_W'(wt_beats(32'(cfg_chin) % WT_CH_TGROUP));
  assign last_group     = (grp_q == groups_q - GRP_W'(1));
  assign last_row       = (rows_left_q == ROWS_W'(1));
  // Only the trailing group of a row can be partial.
  assign gbeats         = (last_group && last_beats_q != '0) ? last_beats_q : CNT_W'(GB);
  assign grp_end        = (k_q == gbeats - CNT_W'(1));
  assign row_end        = last_group && grp_end;
  assign scale_idx      = SIDX_W'(k_q / CNT_W'(BB));
  assign out_valid      = (state_q == StDrain) && !fifo_empty;

  assign busy = (state_q != StIdle);
  assign done = done_q;

  always_comb begin
    state_d          = state_q;
    beat_cnt_d       = beat_cnt_q;
    k_d              = k_q;
    last_beats_d     = last_beats_q;
    groups_d         = groups_q;
    grp_d            = grp_q;
    rows_left_d      = rows_left_q;
    scale_d          = scale_q;
    done_d           = 1'b0;
    fifo_push        = 1'b0;
    fifo_pop         = 1'b0;
    bus.hbm_ready    = 1'b0;
    bus.wt_valid     = out_valid;
    // Payload is zeroed when not valid so idle/reset outputs read as 0.
    bus.wt_data      = out_valid ? fifo_head : '0;
    bus.wt_scale     = out_valid ? scale_q[scale_idx] : '0;
    bus.wt_last      = out_valid && row_end;
    bus.wt_last_row  = out_valid && row_end && last_row;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_rows != '0 && cfg_chin != '0) begin
            state_d      = StFill;
            last_beats_d = cfg_last_beats;
            groups_d     = GRP_W'(cfg_chin / CHIN_W'(WT_CH_TGROUP)) +
                           GRP_W'(cfg_last_beats != '0);
            grp_d        = '0;
            rows_left_d  = cfg_rows;
            beat_cnt_d   = '0;
            k_d          = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StFill: begin
        bus.hbm_ready = 1'b1;
        if (bus.hbm_valid) begin
          fifo_push = 1'b1;
          if (beat_cnt_q == gbeats - CNT_W'(1)) begin
            beat_cnt_d = '0;
            state_d    = StScale;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      StScale: begin
        bus.hbm_ready = 1'b1;
        if (bus.hbm_valid) begin
          scale_d = bus.hbm_data;
          k_d     = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_valid && bus.wt_ready) begin
          fifo_pop = 1'b1;
          if (grp_end) begin
            k_d = '0;
            if (!last_group) begin
              grp_d   = grp_q + GRP_W'(1);
              state_d = StFill;
            end else if (!last_row) begin
              grp_d       = '0;
              rows_left_d = rows_left_q - ROWS_W'(1);
              state_d     = StFill;
            end else begin
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end else begin
            k_d = k_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      beat_cnt_q   <= '0;
      k_q          <= '0;
      last_beats_q <= '0;
      groups_q     <= '0;
      grp_q        <= '0;
      rows_left_q  <= '0;
      scale_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      k_q          <= k_d;
      last_beats_q <= last_beats_d;
      groups_q     <= groups_d;
      grp_q        <= grp_d;
      rows_left_q  <= rows_left_d;
      scale_q      <= scale_d;
      done_q       <= done_d;
    end
  end

  hbm_fc_wt_fifo #(
    .Width (HBM_DW),
    .Depth (GB)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state_q == StIdle),
    .push      (fifo_push && !fifo_full),
    .push_data (bus.hbm_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_hbm_fc_wt_scale_unpacker.sv
module tb_hbm_fc_wt_scale_unpacker;
  import hbm_fc_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [CHIN_W-1:0] cfg_chin;
  logic [ROWS_W-1:0] cfg_rows;
  logic              busy;
  logic              done;

  hbm_fc_wt_scale_unpacker_if bus ();

  hbm_fc_wt_scale_unpacker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg_chin (cfg_chin),
    .cfg_rows (cfg_rows),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  int n_assert, n_fail;
  int cyc;
  int done_cnt, done_cyc, hbm_hs_cnt, stall_cnt;
  int first_valid_cyc, first_hs_cyc, last_hs_cyc, scale_cyc;
  bit busy_seen, bp_en, feed_abort;

  logic [HBM_DW-1:0]   got_data[$],  exp_data[$];
  logic [SCALE_DW-1:0] got_scale[$], exp_scale[$];
  bit                  got_last[$],  exp_last[$];
  bit                  got_lrow[$],  exp_lrow[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [HBM_DW-1:0] wdat(input int r, input int g, input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 ^ 32'((r << 12) | (g << 8) | k);
    return {8{w}};
  endfunction

  // Lane i of the scale beat for (row r, group g) is {r+1, g, 3i+1}.
  function automatic logic [HBM_DW-1:0] sdat(input int r, input int g);
    logic [HBM_DW-1:0] s;
    for (int i = 0; i < 16; i++) s[16*i +: 16] = {4'(r + 1), 4'(g), 8'(i * 3 + 1)};
    return s;
  endfunction

  // wt_ready: always 1, or the repeating 1,0,0,1 pattern under backpressure.
  initial begin
    int ph;
    ph = 0;
    bus.wt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        bus.wt_ready = (ph % 4 == 0) || (ph % 4 == 3);
        ph++;
      end else begin
        bus.wt_ready = 1'b1;
      end
    end
  end

  // Output monitor: records handshakes, checks hold-while-stalled and input stall in drain.
  initial begin
    bit                  stall_pend;
    logic [HBM_DW-1:0]   h_data;
    logic [SCALE_DW-1:0] h_scale;
    logic                h_last, h_lrow;
    stall_pend = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_pend = 0;
      end else begin
        if (stall_pend) begin
          stall_cnt++;
          check_eq("stall valid", 256'(bus.wt_valid), 256'(1));
          check_eq("stall data", bus.wt_data, h_data);
          check_eq("stall scale", 256'(bus.wt_scale), 256'(h_scale));
          check_eq("stall last", 256'(bus.wt_last), 256'(h_last));
          check_eq("stall last_row", 256'(bus.wt_last_row), 256'(h_lrow));
        end
        if (bus.wt_valid) begin
          check_eq("hbm_ready in drain", 256'(bus.hbm_ready), 256'(0));
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (bus.wt_valid && bus.wt_ready) begin
          got_data.push_back(bus.wt_data);
          got_scale.push_back(bus.wt_scale);
          got_last.push_back(bus.wt_last);
          got_lrow.push_back(bus.wt_last_row);
          if (first_hs_cyc < 0) first_hs_cyc = cyc;
          last_hs_cyc = cyc;
        end
        if (bus.hbm_valid && bus.hbm_ready) hbm_hs_cnt++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (busy) busy_seen = 1;
        stall_pend = bus.wt_valid && !bus.wt_ready;
        h_data  = bus.wt_data;
        h_scale = bus.wt_scale;
        h_last  = bus.wt_last;
        h_lrow  = bus.wt_last_row;
      end
    end
  end

  task automatic clear_obs();
    got_data.delete(); got_scale.delete(); got_last.delete(); got_lrow.delete();
    done_cnt = 0; done_cyc = -1; hbm_hs_cnt = 0; stall_cnt = 0;
    first_valid_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1; scale_cyc = -1;
    busy_seen = 0; feed_abort = 0;
  endtask

  task automatic build_exp(input int chin, input int rows);
    int full, lb, ng, nb;
    logic [HBM_DW-1:0] s;
    exp_data.delete(); exp_scale.delete(); exp_last.delete(); exp_lrow.delete();
    full = chin / 2048;
    lb   = (chin % 2048) * 4 / 256;
    ng   = full + ((lb != 0) ? 1 : 0);
    for (int r = 0; r < rows; r++) begin
      for (int g = 0; g < ng; g++) begin
        nb = (g == ng - 1 && lb != 0) ? lb : 32;
        s  = sdat(r, g);
        for (int k = 0; k < nb; k++) begin
          exp_data.push_back(wdat(r, g, k));
          exp_scale.push_back(s[16*(k/2) +: 16]);
          exp_last.push_back(g == ng - 1 && k == nb - 1);
          exp_lrow.push_back(g == ng - 1 && k == nb - 1 && r == rows - 1);
        end
      end
    end
  endtask

  task automatic pulse_start(input int chin, input int rows);
    @(posedge clk);
    #1;
    cfg_chin = CHIN_W'(chin);
    cfg_rows = ROWS_W'(rows);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Presents one beat and returns just after its accepting edge; valid is left high.
  task automatic send(input logic [HBM_DW-1:0] d, output int at);
    at = -1;
    if (feed_abort) return;
    bus.hbm_valid = 1'b1;
    bus.hbm_data  = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.hbm_ready) begin
        at = cyc;
        @(posedge clk);
        #1;
        return;
      end
    end
    check_eq("hbm_ready timeout", 256'(0), 256'(1));
    feed_abort = 1;
  endtask

  task automatic feed_all(input int chin, input int rows);
    int full, lb, ng, nb, at;
    full = chin / 2048;
    lb   = (chin % 2048) * 4 / 256;
    ng   = full + ((lb != 0) ? 1 : 0);
    for (int r = 0; r < rows; r++) begin
      for (int g = 0; g < ng; g++) begin
        nb = (g == ng - 1 && lb != 0) ? lb : 32;
        for (int k = 0; k < nb; k++) send(wdat(r, g, k), at);
        send(sdat(r, g), at);
        if (scale_cyc < 0) scale_cyc = at;
      end
    end
    bus.hbm_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 800 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq({name, " done pulses"}, 256'(done_cnt), 256'(1));
    check_eq({name, " done timing"}, 256'(done_cyc), 256'(last_hs_cyc + 1));
    check_eq({name, " busy low"}, 256'(busy), 256'(0));
    check_eq({name, " first valid"}, 256'(first_valid_cyc), 256'(scale_cyc + 1));
  endtask

  task automatic compare_out(input string name);
    check_eq({name, " beats"}, 256'(got_data.size()), 256'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      check_eq($sformatf("%s data[%0d]", name, i), got_data[i], exp_data[i]);
      check_eq($sformatf("%s scale[%0d]", name, i), 256'(got_scale[i]), 256'(exp_scale[i]));
      check_eq($sformatf("%s last[%0d]", name, i), 256'(got_last[i]), 256'(exp_last[i]));
      check_eq($sformatf("%s last_row[%0d]", name, i), 256'(got_lrow[i]), 256'(exp_lrow[i]));
    end
  endtask

  task automatic run_case(input int chin, input int rows, input bit bp, input string name);
    clear_obs();
    build_exp(chin, rows);
    bp_en = bp;
    pulse_start(chin, rows);
    feed_all(chin, rows);
    wait_done(name);
    compare_out(name);
    bp_en = 0;
  endtask

  task automatic check_idle(input string name);
    check_eq({name, " wt_valid"}, 256'(bus.wt_valid), 256'(0));
    check_eq({name, " wt_data"}, bus.wt_data, 256'(0));
    check_eq({name, " wt_scale"}, 256'(bus.wt_scale), 256'(0));
    check_eq({name, " wt_last"}, 256'(bus.wt_last), 256'(0));
    check_eq({name, " wt_last_row"}, 256'(bus.wt_last_row), 256'(0));
    check_eq({name, " hbm_ready"}, 256'(bus.hbm_ready), 256'(0));
    check_eq({name, " busy"}, 256'(busy), 256'(0));
    check_eq({name, " done"}, 256'(done), 256'(0));
  endtask

  task automatic zero_case(input int chin, input int rows, input string name);
    clear_obs();
    bus.hbm_valid = 1'b1;
    bus.hbm_data  = wdat(7, 7, 7);
    pulse_start(chin, rows);
    @(negedge clk);
    check_eq({name, " done"}, 256'(done), 256'(1));
    check_eq({name, " busy"}, 256'(busy), 256'(0));
    @(negedge clk);
    check_eq({name, " done drop"}, 256'(done), 256'(0));
    repeat (3) @(negedge clk);
    bus.hbm_valid = 1'b0;
    check_eq({name, " done pulses"}, 256'(done_cnt), 256'(1));
    check_eq({name, " no hbm hs"}, 256'(hbm_hs_cnt), 256'(0));
    check_eq({name, " no out"}, 256'(got_data.size()), 256'(0));
    check_eq({name, " busy never"}, 256'(busy_seen), 256'(0));
  endtask

  initial begin
    int at, nlr;
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; cfg_chin = '0; cfg_rows = '0;
    bus.hbm_valid = 1'b0; bus.hbm_data = '0; bp_en = 0;
    clear_obs();
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    // One full group.
    run_case(2048, 1, 0, "c2048");
    check_eq("c2048 throughput", 256'(last_hs_cyc - first_hs_cyc), 256'(31));
    check_eq("c2048 scale0", 256'(got_scale[0]), 256'(16'h1001));
    check_eq("c2048 scale31", 256'(got_scale[31]), 256'(16'h102E));
    check_eq("c2048 last30", 256'(got_last[30]), 256'(0));
    check_eq("c2048 last31", 256'(got_last[31]), 256'(1));
    check_eq("c2048 last_row31", 256'(got_lrow[31]), 256'(1));

    // Full group plus a 4-beat partial group.
    run_case(2304, 1, 0, "c2304");
    check_eq("c2304 last31", 256'(got_last[31]), 256'(0));
    check_eq("c2304 scale32", 256'(got_scale[32]), 256'(16'h1101));
    check_eq("c2304 scale33", 256'(got_scale[33]), 256'(16'h1101));
    check_eq("c2304 scale34", 256'(got_scale[34]), 256'(16'h1104));
    check_eq("c2304 scale35", 256'(got_scale[35]), 256'(16'h1104));
    check_eq("c2304 last35", 256'(got_last[35]), 256'(1));

    // Three single-block rows.
    run_case(128, 3, 0, "c128x3");
    nlr = 0;
    foreach (got_lrow[i]) nlr += got_lrow[i] ? 1 : 0;
    check_eq("c128x3 last_row count", 256'(nlr), 256'(1));
    check_eq("c128x3 last_row5", 256'(got_lrow[5]), 256'(1));
    check_eq("c128x3 last1", 256'(got_last[1]), 256'(1));
    check_eq("c128x3 last3", 256'(got_last[3]), 256'(1));
    check_eq("c128x3 scale2", 256'(got_scale[2]), 256'(16'h2001));

    // Output backpressure with input valid held high.
    run_case(2048, 1, 1, "bp");
    check_eq("bp stalls seen", 256'(stall_cnt != 0), 256'(1));

    // Reset in the middle of a drain.
    clear_obs();
    pulse_start(2048, 1);
    feed_all(2048, 1);
    for (int i = 0; i < 300 && got_data.size() < 10; i++) @(posedge clk);
    check_eq("rst_mid reached beat10", 256'(got_data.size() >= 10), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_mid no done", 256'(done_cnt), 256'(0));
    run_case(128, 1, 0, "after_rst");

    // Start while busy must not relatch the configuration.
    clear_obs();
    build_exp(128, 1);
    pulse_start(128, 1);
    send(wdat(0, 0, 0), at);
    bus.hbm_valid = 1'b0;
    pulse_start(2048, 5);
    check_eq("busy_start busy", 256'(busy), 256'(1));
    send(wdat(0, 0, 1), at);
    send(sdat(0, 0), at);
    scale_cyc = at;
    bus.hbm_valid = 1'b0;
    wait_done("busy_start");
    compare_out("busy_start");
    check_eq("busy_start hbm hs", 256'(hbm_hs_cnt), 256'(3));

    // Zero-sized jobs finish immediately.
    zero_case(0, 4, "zero_chin");
    zero_case(128, 0, "zero_rows");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hbm_fc_wt_scale_unpacker.md
Name: hbm_fc_wt_scale_unpacker

Overview:
- Upstream feeder of the HBM fully-connected (FC) compute stage.
- Consumes the raw HBM weight read stream for one or more output-channel rows. Per row, the layout is: repeated groups of WT_CH_TGROUP weights, each group followed by one scale beat. The last group may be partial.
- Buffers each group's weight beats until its scale beat arrives, then re-emits every weight beat tagged with the FP quant scale of its T_QUANT_BLOCK.

Parameters:
- HBM_DW, 256, HBM AXI data width (bits per beat).
- WT_DW, 4, weight element width.
- SCALE_DW, 16, per-block FP scale width.
- T_QUANT_BLOCK, 128, CHin elements per quant block.
- WT_CH_TGROUP, 2048, CHin per group. Must equal T_QUANT_BLOCK*HBM_DW/SCALE_DW.
- CHIN_W, 16, width of the CHin config field.
- ROWS_W, 16, width of the row-count config field.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; samples cfg_* when idle
- cfg_chin  in  CHIN_W  padded CHin per row; multiple of HBM_DW/WT_DW (64)
- cfg_rows  in  ROWS_W  output-channel rows to process
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after the last output beat of the last row
- hbm_data  in  HBM_DW  HBM read data
- hbm_valid  in  1  input valid
- hbm_ready  out  1  input ready
- wt_data  out  HBM_DW  weight beat
- wt_scale  out  SCALE_DW  scale for wt_data's block
- wt_valid  out  1  output valid
- wt_ready  in  1  output ready
- wt_last  out  1  last beat of the current row
- wt_last_row  out  1  wt_last of the final row

Behaviour:
- Reset values: all outputs 0 (busy, done, hbm_ready, wt_valid, wt_last, wt_last_row, wt_data, wt_scale). FSM goes to IDLE, FIFO is emptied, counters are 0.
- Constants:
  - GB = WT_CH_TGROUP*WT_DW/HBM_DW (32), beats per full group.
  - BB = T_QUANT_BLOCK*WT_DW/HBM_DW (2), beats per block.
- Per-row geometry, latched at start:
  - full_groups = cfg_chin / WT_CH_TGROUP
  - last_beats = (cfg_chin % WT_CH_TGROUP)*WT_DW/HBM_DW
  - groups per row = full_groups + (last_beats != 0)
  - the current group's beat count gbeats is GB, or last_beats for the trailing partial group.
- FSM states: IDLE, FILL, SCALE, DRAIN.
  - IDLE: start with cfg_rows != 0 and cfg_chin != 0 -> FILL next cycle, busy=1. start with a zero field -> done pulses next cycle, busy stays 0. start in any other state is ignored.
  - FILL: hbm_ready=1. Each hbm_valid&&hbm_ready pushes into the FIFO and increments beat_cnt. On the gbeats-th push -> SCALE.
  - SCALE: hbm_ready=1. The handshake latches hbm_data into scale_reg -> DRAIN. The FIFO is not written.
  - DRAIN: hbm_ready=0. wt_valid = FIFO not empty.
    - wt_data = FIFO head (first-word-fall-through).
    - wt_scale = scale_reg[SCALE_DW*(k/BB) +: SCALE_DW], where k is the beat index within the group; a partial block uses index k/BB.
    - Pop on wt_valid&&wt_ready.
    - After the last pop of the group: if groups remain in the row -> FILL. Else if rows remain -> FILL for the next row. Else -> IDLE with done=1 for one cycle and busy=0 on the same edge.
    - wt_last is set on the last beat of the last group of each row. wt_last_row = wt_last on the final row.
- Output rules:
  - wt_data, wt_scale, wt_last and wt_last_row are stable while wt_valid && !wt_ready.
  - wt_valid never drops without a handshake.
- Timing:
  - No fill/drain overlap; input is stalled during DRAIN.
  - First wt_valid appears 1 cycle after the scale-beat handshake.
  - Output sustains one beat/cycle when wt_ready=1.
- FIFO: depth GB, registered. Never overflows by construction (FILL is bounded by gbeats).
- Reset mid-operation: asserting rst_n low discards FIFO contents and returns to IDLE. There is no done pulse.

Decomposition:
- Package hbm_fc_pkg holds:
  - GB, BB, derived widths: $clog2(GB+1) for the FIFO/beat counter, group-counter width from CHIN_W.
  - the state enum {IDLE,FILL,SCALE,DRAIN}.
- One sub-module: hbm_fc_wt_fifo, a synchronous first-word-fall-through FIFO.
  - Parameters: width HBM_DW, depth GB.
  - Ports: push, pop, full, empty, clear.

Test Plan:
- cfg_chin=2048, cfg_rows=1; 32 weight beats D0..D31 then scale S:
  - 32 output beats; beat k carries Dk with wt_scale=S[16*(k/2)+:16].
  - wt_last=wt_last_row=1 on beat 31; done 1 cycle after.
- cfg_chin=2304, cfg_rows=1:
  - group 0 = 32 beats plus scale S0; group 1 = 4 beats plus scale S1.
  - Group-1 beats use S1[15:0], S1[15:0], S1[31:16], S1[31:16]; wt_last on the 4th.
- cfg_chin=128, cfg_rows=3:
  - 2 beats plus scale per row; wt_last on every 2nd output beat.
  - wt_last_row only on output beat 6; one done pulse.
- Backpressure: wt_ready toggles 1,0,0,1 during DRAIN; hbm_valid is held high throughout.
  - Outputs stay stable while stalled and all 32 beats arrive in order.
  - hbm_ready=0 throughout DRAIN.
- Reset mid-operation: deassert rst_n at output beat 10 of 32.
  - All outputs 0 and busy=0; a new start with cfg_chin=128 produces exactly 2 beats.
- start while busy is ignored (cfg not relatched).
- cfg_rows=0 or cfg_chin=0: done pulses 1 cycle after start, with no handshakes and busy never asserted.
